// File: rtl/sc_micro_sequencer.sv
// sc_micro_sequencer
//   Microprogram sequencer. It holds the control-store address register
//   (micro-PC) and picks each next address from the branch-control select:
//   addr+1, a MIR jump address, or an IR-opcode decode address. The micro-PC
//   stalls while a memory access is pending. A terminal halt is supported.
//
// Ports
//   SC_MicroSeq_CLOCK_50         in   clock, rising edge
//   SC_MicroSeq_RESET_InLow      in   synchronous reset, active low
//   SC_MicroSeq_Branch_Select_In in   00 next, 01 jump, 10 decode, 11 illegal
//   SC_MicroSeq_Jump_Addr_In     in   MIR jump address field
//   SC_MicroSeq_IR_OP_In         in   IR opcode bits used for decode
//   SC_MicroSeq_Mem_Req_In       in   current microinstruction reads or writes
//   SC_MicroSeq_Mem_Ack_In       in   memory completed the access this cycle
//   SC_MicroSeq_Halt_In          in   halt request from microcode
//   SC_MicroSeq_CS_Addr_Out      out  registered micro-PC
//   SC_MicroSeq_Advance_Out      out  micro-PC updates at the next edge
//   SC_MicroSeq_Stall_Out        out  inverse of Advance_Out
//   SC_MicroSeq_Halted_Out       out  registered, 1 while halted
//   SC_MicroSeq_Illegal_Sel_Out  out  registered, sticky: select 11 was consumed
module sc_micro_sequencer #(
  parameter int DATAWIDTH_CS_ADDR       = 11,
  parameter int DATAWIDTH_BUS_OUT       = 2,
  parameter int DATAWIDTH_BUS_REG_IR_OP = 8,
  parameter logic [DATAWIDTH_CS_ADDR-1:0] RESET_ADDR = '0
) (
  input  logic                               SC_MicroSeq_CLOCK_50,
  input  logic                               SC_MicroSeq_RESET_InLow,
  input  logic [DATAWIDTH_BUS_OUT-1:0]       SC_MicroSeq_Branch_Select_In,
  input  logic [DATAWIDTH_CS_ADDR-1:0]       SC_MicroSeq_Jump_Addr_In,
  input  logic [DATAWIDTH_BUS_REG_IR_OP-1:0] SC_MicroSeq_IR_OP_In,
  input  logic                               SC_MicroSeq_Mem_Req_In,
  input  logic                               SC_MicroSeq_Mem_Ack_In,
  input  logic                               SC_MicroSeq_Halt_In,
  output logic [DATAWIDTH_CS_ADDR-1:0]       SC_MicroSeq_CS_Addr_Out,
  output logic                               SC_MicroSeq_Advance_Out,
  output logic                               SC_MicroSeq_Stall_Out,
  output logic                               SC_MicroSeq_Halted_Out,
  output logic                               SC_MicroSeq_Illegal_Sel_Out
);

  localparam logic [DATAWIDTH_BUS_OUT-1:0] SEL_NEXT   = 2'b00;
  localparam logic [DATAWIDTH_BUS_OUT-1:0] SEL_JUMP   = 2'b01;
  localparam logic [DATAWIDTH_BUS_OUT-1:0] SEL_DECODE = 2'b10;

  typedef enum logic [1:0] {
    ST_RST      = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  state_t                         state_reg, state_next;
  logic [DATAWIDTH_CS_ADDR-1:0]   addr_reg, addr_nxt;
  logic                           halted_reg;
  logic                           illegal_reg;
  logic                           advance;
  logic                           sel_illegal;

  // Candidate next address; only committed when advance is high.
  // Select 11 behaves like 00 but raises the sticky illegal flag.
  always_comb begin
    addr_nxt    = addr_reg + 1'b1;
    sel_illegal = 1'b0;
    case (SC_MicroSeq_Branch_Select_In)
      SEL_NEXT:   addr_nxt = addr_reg + 1'b1;
      SEL_JUMP:   addr_nxt = SC_MicroSeq_Jump_Addr_In;
      SEL_DECODE: addr_nxt = {1'b1, SC_MicroSeq_IR_OP_In, 2'b00};
      default: begin
        addr_nxt    = addr_reg + 1'b1;
        sel_illegal = 1'b1;
      end
    endcase
  end

  // State transitions and the advance strobe. Advance deliberately depends
  // only on state and the handshake/halt inputs, never on the select.
  always_comb begin
    state_next = state_reg;
    advance    = 1'b0;
    case (state_reg)
      ST_RST: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (SC_MicroSeq_Halt_In) begin
          state_next = ST_HALT;
        end else if (SC_MicroSeq_Mem_Req_In && !SC_MicroSeq_Mem_Ack_In) begin
          state_next = ST_WAIT_MEM;
        end else begin
          advance = 1'b1;
        end
      end
      ST_WAIT_MEM: begin
        // Halt is not honoured here: the pending access finishes first.
        if (SC_MicroSeq_Mem_Ack_In) begin
          state_next = ST_RUN;
          advance    = 1'b1;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_RST;
      end
    endcase
  end

  always_ff @(posedge SC_MicroSeq_CLOCK_50) begin
    if (!SC_MicroSeq_RESET_InLow) begin
      state_reg   <= ST_RST;
      addr_reg    <= RESET_ADDR;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      halted_reg <= (state_next == ST_HALT);
      if (advance) begin
        addr_reg <= addr_nxt;
        if (sel_illegal) begin
          illegal_reg <= 1'b1;
        end
      end
    end
  end

  assign SC_MicroSeq_CS_Addr_Out     = addr_reg;
  assign SC_MicroSeq_Advance_Out     = advance;
  assign SC_MicroSeq_Stall_Out       = ~advance;
  assign SC_MicroSeq_Halted_Out      = halted_reg;
  assign SC_MicroSeq_Illegal_Sel_Out = illegal_reg;

endmodule

// File: tb/tb_sc_micro_sequencer.sv
// tb_sc_micro_sequencer
//   Directed-vector bench with a scoreboard. The driver applies one vector per
//   cycle just after the rising edge and pushes the outputs expected during
//   that cycle; the monitor pops and compares on the falling edge.
//   An expected field of -1 means "not checked" (e.g. before the first reset).
module tb_sc_micro_sequencer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic [10:0] jump;
  logic [7:0]  ir_op;
  logic        req;
  logic        ack;
  logic        halt;
  logic [10:0] cs_addr;
  logic        advance;
  logic        stall;
  logic        halted;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string name;
    int    addr;
    int    adv;
    int    halted;
    int    illegal;
  } exp_t;

  exp_t exp_q[$];

  sc_micro_sequencer dut (
    .SC_MicroSeq_CLOCK_50         (clk),
    .SC_MicroSeq_RESET_InLow      (rst_n),
    .SC_MicroSeq_Branch_Select_In (sel),
    .SC_MicroSeq_Jump_Addr_In     (jump),
    .SC_MicroSeq_IR_OP_In         (ir_op),
    .SC_MicroSeq_Mem_Req_In       (req),
    .SC_MicroSeq_Mem_Ack_In       (ack),
    .SC_MicroSeq_Halt_In          (halt),
    .SC_MicroSeq_CS_Addr_Out      (cs_addr),
    .SC_MicroSeq_Advance_Out      (advance),
    .SC_MicroSeq_Stall_Out        (stall),
    .SC_MicroSeq_Halted_Out       (halted),
    .SC_MicroSeq_Illegal_Sel_Out  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_field(input string name, input string field,
                             input int act, input int req_v);
    if (req_v >= 0) begin
      checks++;
      if (act != req_v) begin
        failures++;
        $display("FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, req_v);
      end
    end
  endtask

  // Monitor: every falling edge with a pending expectation is one transaction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_field(e.name, "addr",    int'(cs_addr), e.addr);
      check_field(e.name, "advance", int'(advance), e.adv);
      if (e.adv >= 0) check_field(e.name, "stall", int'(stall), 1 - e.adv);
      check_field(e.name, "halted",  int'(halted),  e.halted);
      check_field(e.name, "illegal", int'(illegal), e.illegal);
      $display("txn %-10s addr=0x%03h adv=%0b stall=%0b halted=%0b illegal=%0b",
               e.name, cs_addr, advance, stall, halted, illegal);
    end
  end

  // One vector per cycle; expectations describe the outputs seen while the
  // vector is applied (i.e. before the edge that consumes it).
  task automatic step(input string name, input logic r, input logic [1:0] s,
                      input logic [10:0] j, input logic [7:0] op,
                      input logic rq, input logic ak, input logic h,
                      input int e_addr, input int e_adv,
                      input int e_halt, input int e_ill);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; sel = s; jump = j; ir_op = op; req = rq; ack = ak; halt = h;
    e.name = name; e.addr = e_addr; e.adv = e_adv;
    e.halted = e_halt; e.illegal = e_ill;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; sel = 2'b00; jump = '0; ir_op = '0;
    req = 1'b0; ack = 1'b0; halt = 1'b0;

    //    name         rst sel  jump     ir     rq ak hl  addr   adv h  i
    // T1: reset for three edges, then count up from 0
    step("rst0",       0, 2'b00, 11'h000, 8'h00, 0, 0, 0, -1,    -1, -1, -1);
    step("rst1",       0, 2'b00, 11'h000, 8'h00, 0, 0, 0, 'h000, 0,  0,  0);
    step("rst2",       0, 2'b00, 11'h000, 8'h00, 0, 0, 0, 'h000, 0,  0,  0);
    step("rst_state",  1, 2'b00, 11'h000, 8'h00, 0, 0, 0, 'h000, 0,  0,  0);
    step("run0",       1, 2'b00, 11'h000, 8'h00, 0, 0, 0, 'h000, 1,  0,  0);
    step("run1",       1, 2'b00, 11'h000, 8'h00, 0, 0, 0, 'h001, 1,  0,  0);
    step("run2",       1, 2'b00, 11'h000, 8'h00, 0, 0, 0, 'h002, 1,  0,  0);
    step("run3",       1, 2'b00, 11'h000, 8'h00, 0, 0, 0, 'h003, 1,  0,  0);
    // T2: jump then IR decode
    step("jump",       1, 2'b01, 11'h5A0, 8'h00, 0, 0, 0, 'h004, 1,  0,  0);
    step("decode",     1, 2'b10, 11'h000, 8'hB4, 0, 0, 0, 'h5A0, 1,  0,  0);
    step("jmp010",     1, 2'b01, 11'h010, 8'h00, 0, 0, 0, 'h6D0, 1,  0,  0);
    // T3: memory wait, then same-cycle req/ack
    step("memreq",     1, 2'b00, 11'h000, 8'h00, 1, 0, 0, 'h010, 0,  0,  0);
    step("wait1",      1, 2'b01, 11'h3FF, 8'h00, 1, 0, 0, 'h010, 0,  0,  0);
    step("wait2",      1, 2'b00, 11'h000, 8'h00, 1, 0, 0, 'h010, 0,  0,  0);
    step("memack",     1, 2'b00, 11'h000, 8'h00, 1, 1, 0, 'h010, 1,  0,  0);
    step("reqack",     1, 2'b00, 11'h000, 8'h00, 1, 1, 0, 'h011, 1,  0,  0);
    step("jmp7ff",     1, 2'b01, 11'h7FF, 8'h00, 0, 0, 0, 'h012, 1,  0,  0);
    // T4: wrap 0x7FF -> 0x000
    step("wrap",       1, 2'b00, 11'h000, 8'h00, 0, 0, 0, 'h7FF, 1,  0,  0);
    step("jmp005",     1, 2'b01, 11'h005, 8'h00, 0, 0, 0, 'h000, 1,  0,  0);
    // T5: illegal select, sticky under legal selects
    step("illegal",    1, 2'b11, 11'h000, 8'h00, 0, 0, 0, 'h005, 1,  0,  0);
    step("sticky0",    1, 2'b00, 11'h000, 8'h00, 0, 0, 0, 'h006, 1,  0,  1);
    step("sticky1",    1, 2'b01, 11'h100, 8'h00, 0, 0, 0, 'h007, 1,  0,  1);
    step("sticky2",    1, 2'b10, 11'h000, 8'h00, 0, 0, 0, 'h100, 1,  0,  1);
    // T6: halt in RUN, frozen while inputs toggle, exit only via reset
    step("halt",       1, 2'b01, 11'h123, 8'h00, 0, 0, 1, 'h400, 0,  0,  1);
    step("halted1",    1, 2'b11, 11'h234, 8'hFF, 0, 1, 0, 'h400, 0,  1,  1);
    step("halted2",    1, 2'b00, 11'h000, 8'h00, 0, 0, 0, 'h400, 0,  1,  1);
    step("rst_halt",   0, 2'b00, 11'h000, 8'h00, 0, 0, 0, 'h400, 0,  1,  1);
    step("rst_st2",    1, 2'b00, 11'h000, 8'h00, 0, 0, 0, 'h000, 0,  0,  0);
    step("jmp020",     1, 2'b01, 11'h020, 8'h00, 0, 0, 0, 'h000, 1,  0,  0);
    // halt ignored during WAIT_MEM; unconsumed select 11 must not flag
    step("memreq2",    1, 2'b11, 11'h000, 8'h00, 1, 0, 0, 'h020, 0,  0,  0);
    step("waithalt",   1, 2'b11, 11'h000, 8'h00, 1, 0, 1, 'h020, 0,  0,  0);
    step("ackhalt",    1, 2'b00, 11'h000, 8'h00, 1, 1, 1, 'h020, 1,  0,  0);
    // reset while in WAIT_MEM
    step("memreq3",    1, 2'b00, 11'h000, 8'h00, 1, 0, 0, 'h021, 0,  0,  0);
    step("rst_wait",   0, 2'b00, 11'h000, 8'h00, 1, 0, 0, 'h021, 0,  0,  0);
    step("rst_st3",    1, 2'b00, 11'h000, 8'h00, 1, 0, 0, 'h000, 0,  0,  0);
    step("run_after",  1, 2'b00, 11'h000, 8'h00, 0, 0, 0, 'h000, 1,  0,  0);
    step("halt2",      1, 2'b00, 11'h000, 8'h00, 0, 0, 1, 'h001, 0,  0,  0);
    step("halted3",    1, 2'b01, 11'h555, 8'h00, 0, 0, 0, 'h001, 0,  1,  0);

    // Drain the scoreboard with a bounded wait.
    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
